// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter and frame sequencer that shares one RS232 TX line between two byte requesters.
// Bit timing comes from an external baud/bit counter block held cleared while this block is idle.
module rs232_tx_arbiter #(
    parameter int DATA_WIDTH       = 8,
    parameter int PARITY_EN        = 1,
    parameter int ODD_PARITY       = 0,
    parameter int TOTAL_DATA_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  baud_clock_rising_edge,
    input  logic                  all_bits_transmitted,
    output logic                  reset_counters,
    output logic                  serial_data_out,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  frame_done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]                  state;
    logic [TOTAL_DATA_WIDTH-1:0] shift_reg;
    logic [TOTAL_DATA_WIDTH-1:0] frame;
    logic [DATA_WIDTH-1:0]       win_data;
    logic                        last_grant;
    logic                        winner;
    logic                        accept;
    logic                        parity;

    assign reset_counters = (state == IDLE);
    assign busy           = (state == SEND);

    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign accept   = req0_ready | req1_ready;
    assign winner   = req1_ready;
    assign win_data = req1_ready ? req1_data : req0_data;
    assign parity   = (^win_data) ^ (ODD_PARITY != 0);

    // Frame layout from LSB: start(0), data LSB first, optional parity, stop(1).
    always_comb begin
        frame                 = '1;
        frame[0]              = 1'b0;
        frame[DATA_WIDTH:1]   = win_data;
        if (PARITY_EN != 0) begin
            frame[DATA_WIDTH+1] = parity;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift_reg       <= '1;
            serial_data_out <= 1'b1;
            grant_id        <= 1'b0;
            last_grant      <= 1'b1;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= frame;
                        grant_id   <= winner;
                        last_grant <= winner;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // End of frame wins over a coincident baud edge; the stop level carries into idle.
                    if (all_bits_transmitted) begin
                        frame_done      <= 1'b1;
                        serial_data_out <= 1'b1;
                        state           <= IDLE;
                    end else if (baud_clock_rising_edge) begin
                        serial_data_out <= shift_reg[0];
                        shift_reg       <= {1'b1, shift_reg[TOTAL_DATA_WIDTH-1:1]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
